// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC controller datapath: FSM state encoding,
// default data width and the index-width helper.
package rtc_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int W_DEF = 8;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_OWN  = ST_OWN
  } state_e;

  // Ceil log2, but never below one bit so single-select indices stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_nz.sv
// Combinational priority encoder: returns the lowest channel whose data is
// nonzero, plus a flag telling whether any channel was nonzero at all.
module prio_enc_nz
  import rtc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = W_DEF,
  parameter int IDX_W = clog2_min1(NCH)
) (
  input  logic [NCH*W-1:0] ch_data,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top down lets the lowest nonzero channel overwrite last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_data[i*W +: W] != '0) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_prio_data_mux.sv
// Registered N-channel priority data selector with an ownership lock window,
// optional hold of the last value and ownership/change status outputs.
module rtc_prio_data_mux
  import rtc_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = W_DEF,
  parameter int LOCK_CYC = 4,
  parameter int HOLD     = 1,
  parameter int IDX_W    = clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NCH*W-1:0] ch_data,
  output logic [W-1:0]     y,
  output logic [IDX_W-1:0] sel_idx,
  output logic             y_valid,
  output logic             sel_change
);

  localparam int CNT_W = clog2_min1(LOCK_CYC + 1);

  state_e             state_q, state_d;
  logic [W-1:0]       y_q, y_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic               y_valid_q, y_valid_d;
  logic               sel_change_q, sel_change_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   cand_idx;
  logic               cand_found;
  logic [W-1:0]       cand_data;
  logic [W-1:0]       own_data;
  logic               expired;

  prio_enc_nz #(
    .NCH   (NCH),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_enc (
    .ch_data (ch_data),
    .idx     (cand_idx),
    .found   (cand_found)
  );

  always_comb begin
    cand_data = '0;
    own_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cand_idx == IDX_W'(i))  cand_data = ch_data[i*W +: W];
      if (sel_idx_q == IDX_W'(i)) own_data  = ch_data[i*W +: W];
    end
  end

  assign expired = (LOCK_CYC == 0) || (cnt_q == CNT_W'(LOCK_CYC));

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    sel_idx_d    = sel_idx_q;
    y_valid_d    = y_valid_q;
    sel_change_d = 1'b0;
    cnt_d        = cnt_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (cand_found) begin
            state_d      = S_OWN;
            y_d          = cand_data;
            sel_idx_d    = cand_idx;
            y_valid_d    = 1'b1;
            sel_change_d = 1'b1;
            cnt_d        = '0;
          end else if (HOLD == 0) begin
            y_d       = '0;
            y_valid_d = 1'b0;
          end
        end
        default: begin
          if (!expired) begin
            // Inside the lock: keep the owner, hold its last nonzero byte.
            if (own_data != '0) y_d = own_data;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (cand_found && (cand_idx == sel_idx_q)) begin
            y_d = own_data;
          end else if (cand_found) begin
            y_d          = cand_data;
            sel_idx_d    = cand_idx;
            sel_change_d = 1'b1;
            cnt_d        = '0;
          end else begin
            state_d = S_IDLE;
            if (HOLD == 0) begin
              y_d       = '0;
              y_valid_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      y_q          <= '0;
      sel_idx_q    <= '0;
      y_valid_q    <= 1'b0;
      sel_change_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      sel_idx_q    <= sel_idx_d;
      y_valid_q    <= y_valid_d;
      sel_change_q <= sel_change_d;
      cnt_q        <= cnt_d;
    end
  end

  assign y          = y_q;
  assign sel_idx    = sel_idx_q;
  assign y_valid    = y_valid_q;
  assign sel_change = sel_change_q;

endmodule
